jtcps1_gfx_bankmap: RTL and testbench
=====================================

Name: jtcps1_gfx_bankmap

Overview:
- Table-driven graphics ROM bank mapper for the CPS1 tile/sprite fetch path; replaces per-game hardwired bank equations with a range table loaded by the ROM downloader.
- Each lookup (layer, tile code) is matched against ENTRIES programmable ranges, selects one of BANKS bank registers, and returns that bank's offset/mask to the ROM address generator.
- Pipelined, with valid/ready handshakes on both sides, so SCROLL/OBJ fetch engines can share one instance.

Parameters:
- BANKS, 4, number of bank offset/mask register pairs; BANKS ≤ 16
- ENTRIES, 8, number of range table entries; power of two
- CW, 10, tile code width compared against ranges; CW ≤ 16
- LAYERS, 5, number of layer codes (0 OBJ, 1-3 SCROLL1-3, 4 star field); LAYERS ≤ 7
- OW, 4, offset/mask width per bank

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- prog_we  in  1  table byte write strobe
- prog_addr  in  $clog2(ENTRIES)+3  {entry, byte}
- prog_data  in  8  table byte
- bank_offset  in  BANKS*OW  packed offsets; bank k at [k*OW +: OW]
- bank_mask  in  BANKS*OW  packed masks, same packing
- lu_req  in  1  lookup request valid
- lu_ready  out  1  lookup accepted when lu_req & lu_ready
- lu_layer  in  3  layer code
- lu_code  in  CW  tile code
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_offset  out  OW  selected offset
- out_mask  out  OW  selected mask
- out_hit  out  1  1 = range matched, 0 = default

Behaviour:
- Entry byte layout:
  - byte0: bit7 valid; bits[LAYERS-1:0] layer enable mask
  - bytes1-2: code_lo, little endian
  - bytes3-4: code_hi, little endian
  - byte5: bank index [3:0]
  - bytes 6-7 ignored. Code bits above CW are ignored.
- Write timing: a write lands on the clock edge where prog_we=1. It affects lookups entering stage 1 on later cycles.
- Match condition for entry e: valid, layer mask bit[lu_layer] set, code_lo ≤ lu_code ≤ code_hi (inclusive, unsigned).
  - code_lo > code_hi never matches.
  - lu_layer ≥ LAYERS never matches.
  - Bank index ≥ BANKS counts as a hit but returns the default values.
- Priority: lowest matching entry index wins.
- Pipeline:
  - Stage 1 registers the compare and priority encode (winning bank index + hit).
  - Stage 2 registers the offset/mask mux from the bank_* inputs, sampled at the stage-2 load edge.
  - Latency: 2 cycles from acceptance to out_valid with no stall.
- Handshake:
  - Standard valid/ready. Each stage advances when empty or when its downstream consumes.
  - lu_ready = ~s1_full | s1 advancing. Sustains 1 lookup/cycle while out_ready=1.
  - Results stay stable while out_valid & ~out_ready. No drops, no duplicates, order preserved.
- Miss/default result: out_offset=0, out_mask=all ones, out_hit=0.
- Reset (async assert, sync release):
  - All entry valid bits cleared; stages emptied.
  - Outputs: out_valid=0, out_offset=0, out_mask=all ones, out_hit=0, lu_ready=1 from the first cycle after release.
  - Reset mid-operation discards in-flight lookups.

Optional Feature:
- Macro: JTCPS1_BANKMAP_MISS_EN.
- When defined:
  - Adds output miss_cnt [15:0], saturating at 16'hFFFF, incremented on each result with out_hit=0 consumed at the output.
  - Adds sticky output miss_flag.
  - Both cleared by reset or by prog_we.
- When undefined: no such ports or logic exist.

Test Plan:
- Reset, no programming; lookup layer 1, code 10'h123 -> after 2 cycles out_valid=1, hit=0, offset=0, mask=4'hF.
- Entry0: layers {1}, range 0x000-0x1FF, bank 2; bank2 = offset 4'h8, mask 4'h7. Lookup (1, 0x1FF) -> hit=1, offset 8, mask 7. Lookup (1, 0x200) -> hit=0.
- Entry0 range 0x100-0x2FF bank 1; entry3 range 0x000-0x3FF bank 3. Lookup (2, 0x150) -> bank1 wins. Lookup (2, 0x050) -> bank3.
- Back-to-back 8 lookups with out_ready low for cycles 3-6 -> lu_ready drops when both stages are full; all 8 results delivered in order, none lost.
- Entry0 code_lo=0x300, code_hi=0x100 -> lookups 0x100, 0x200, 0x300 all miss. Layer code 6 with mask 8'h7F -> miss.
- With JTCPS1_BANKMAP_MISS_EN defined: 3 misses consumed -> miss_cnt=3, miss_flag=1. A prog_we pulse -> both clear.

Source files
------------

// File: rtl/jtcps1_gfx_bankmap.sv
// jtcps1_gfx_bankmap
//   Table-driven graphics ROM bank mapper for the CPS1 tile/sprite fetch path.
//   A lookup (layer, tile code) is compared against ENTRIES programmable ranges.
//   The lowest-index matching entry picks one of BANKS offset/mask pairs, which
//   is returned to the ROM address generator. The datapath is a two-stage
//   pipeline with valid/ready handshakes on both sides.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   prog_we/addr/data     range table byte writes, addr = {entry, byte}
//   bank_offset/mask      packed per-bank offset/mask, bank k at [k*OW +: OW]
//   lu_req/ready/layer/code  lookup request side
//   out_valid/ready/offset/mask/hit  result side
//
// Optional feature (define JTCPS1_BANKMAP_MISS_EN)
//   miss_cnt   saturating count of consumed results with out_hit=0
//   miss_flag  sticky, set by any consumed miss
//   Both are cleared by reset or by any prog_we write.
//
// Entry byte layout
//   0: bit7 valid, bits[LAYERS-1:0] layer enable
//   1-2: code_lo (LE), 3-4: code_hi (LE), 5: bank index [3:0], 6-7 ignored

module jtcps1_gfx_bankmap #(
  parameter int unsigned BANKS   = 4,
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned CW      = 10,
  parameter int unsigned LAYERS  = 5,
  parameter int unsigned OW      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prog_we,
  input  logic [$clog2(ENTRIES)+2:0]   prog_addr,
  input  logic [7:0]                   prog_data,
  input  logic [BANKS*OW-1:0]          bank_offset,
  input  logic [BANKS*OW-1:0]          bank_mask,
  input  logic                         lu_req,
  output logic                         lu_ready,
  input  logic [2:0]                   lu_layer,
  input  logic [CW-1:0]                lu_code,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OW-1:0]                out_offset,
  output logic [OW-1:0]                out_mask,
  output logic                         out_hit
`ifdef JTCPS1_BANKMAP_MISS_EN
  ,
  output logic [15:0]                  miss_cnt,
  output logic                         miss_flag
`endif
);

  localparam int unsigned EW = $clog2(ENTRIES);

  // Range table
  logic [ENTRIES-1:0] r_valid;
  logic [LAYERS-1:0]  r_lmask [ENTRIES];
  logic [CW-1:0]      r_lo    [ENTRIES];
  logic [CW-1:0]      r_hi    [ENTRIES];
  logic [3:0]         r_bank  [ENTRIES];

  logic [EW-1:0]      w_wr_entry;
  logic [2:0]         w_wr_byte;

  assign w_wr_entry = prog_addr[EW+2:3];
  assign w_wr_byte  = prog_addr[2:0];

  // Code bits at or above CW are dropped; bit b of a 16-bit code lives in
  // byte (b / 8) of its little-endian pair, at position b % 8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        r_lmask[e] <= '0;
        r_lo[e]    <= '0;
        r_hi[e]    <= '0;
        r_bank[e]  <= '0;
      end
    end else if (prog_we) begin
      case (w_wr_byte)
        3'd0: begin
          r_valid[w_wr_entry] <= prog_data[7];
          r_lmask[w_wr_entry] <= prog_data[LAYERS-1:0];
        end
        3'd1: begin
          for (int b = 0; b < int'(CW); b++) begin
            if (b < 8) r_lo[w_wr_entry][b] <= prog_data[b % 8];
          end
        end
        3'd2: begin
          for (int b = 0; b < int'(CW); b++) begin
            if (b >= 8) r_lo[w_wr_entry][b] <= prog_data[b % 8];
          end
        end
        3'd3: begin
          for (int b = 0; b < int'(CW); b++) begin
            if (b < 8) r_hi[w_wr_entry][b] <= prog_data[b % 8];
          end
        end
        3'd4: begin
          for (int b = 0; b < int'(CW); b++) begin
            if (b >= 8) r_hi[w_wr_entry][b] <= prog_data[b % 8];
          end
        end
        3'd5: r_bank[w_wr_entry] <= prog_data[3:0];
        default: ;
      endcase
    end
  end

  // Layer masks zero-extended to 8 bits so any 3-bit layer code can index
  // them; layer codes >= LAYERS land on zero bits and never match.
  logic [7:0] w_lmask_pad [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_lmask
    assign w_lmask_pad[g] = 8'(r_lmask[g]);
  end

  logic [ENTRIES-1:0] w_match;
  logic               w_hit;
  logic [3:0]         w_bank;

  always_comb begin
    w_match = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      w_match[e] = r_valid[e] && w_lmask_pad[e][lu_layer] &&
                   (r_lo[e] <= lu_code) && (lu_code <= r_hi[e]);
    end
  end

  // Scan from the top so the lowest matching index is assigned last.
  always_comb begin
    w_hit  = 1'b0;
    w_bank = '0;
    for (int e = int'(ENTRIES) - 1; e >= 0; e--) begin
      if (w_match[e]) begin
        w_hit  = 1'b1;
        w_bank = r_bank[e];
      end
    end
  end

  // Pipeline control
  logic       r_s1_full;
  logic       r_s1_hit;
  logic [3:0] r_s1_bank;
  logic       r_s2_full;
  logic [OW-1:0] r_out_offset;
  logic [OW-1:0] r_out_mask;
  logic       r_out_hit;
  logic       w_s2_free;

  assign w_s2_free = ~r_s2_full | out_ready;
  // Stage 1 can take a new lookup when empty or when it drains into stage 2.
  assign lu_ready  = ~r_s1_full | w_s2_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_full <= 1'b0;
      r_s1_hit  <= 1'b0;
      r_s1_bank <= '0;
    end else if (lu_ready) begin
      r_s1_full <= lu_req;
      if (lu_req) begin
        r_s1_hit  <= w_hit;
        r_s1_bank <= w_bank;
      end
    end
  end

  // Bank select; an out-of-range bank index is a hit with default values.
  logic [OW-1:0] w_offset;
  logic [OW-1:0] w_mask;

  always_comb begin
    w_offset = '0;
    w_mask   = '1;
    if (r_s1_hit) begin
      for (int unsigned k = 0; k < BANKS; k++) begin
        if (r_s1_bank == 4'(k)) begin
          w_offset = bank_offset[k*OW +: OW];
          w_mask   = bank_mask[k*OW +: OW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_full    <= 1'b0;
      r_out_offset <= '0;
      r_out_mask   <= '1;
      r_out_hit    <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_full <= r_s1_full;
      if (r_s1_full) begin
        r_out_offset <= w_offset;
        r_out_mask   <= w_mask;
        r_out_hit    <= r_s1_hit;
      end
    end
  end

  assign out_valid  = r_s2_full;
  assign out_offset = r_out_offset;
  assign out_mask   = r_out_mask;
  assign out_hit    = r_out_hit;

`ifdef JTCPS1_BANKMAP_MISS_EN
  logic [15:0] r_miss_cnt;
  logic        r_miss_flag;
  logic        w_miss_take;

  assign w_miss_take = r_s2_full & out_ready & ~r_out_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt  <= '0;
      r_miss_flag <= 1'b0;
    end else if (prog_we) begin
      r_miss_cnt  <= '0;
      r_miss_flag <= 1'b0;
    end else if (w_miss_take) begin
      r_miss_flag <= 1'b1;
      if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign miss_cnt  = r_miss_cnt;
  assign miss_flag = r_miss_flag;
`endif

endmodule

// File: tb/tb_jtcps1_gfx_bankmap.sv
// Bench for jtcps1_gfx_bankmap: table-driven lookups against hand-derived
// expected results, a result scoreboard fed at issue time, plus sequences for
// latency, back-pressure, reset and the optional miss counter.

module tb_jtcps1_gfx_bankmap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [15:0] bank_offset;
  logic [15:0] bank_mask;
  logic        lu_req;
  logic        lu_ready;
  logic [2:0]  lu_layer;
  logic [9:0]  lu_code;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_offset;
  logic [3:0]  out_mask;
  logic        out_hit;
`ifdef JTCPS1_BANKMAP_MISS_EN
  logic [15:0] miss_cnt;
  logic        miss_flag;
`endif

  jtcps1_gfx_bankmap dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .bank_offset (bank_offset),
    .bank_mask   (bank_mask),
    .lu_req      (lu_req),
    .lu_ready    (lu_ready),
    .lu_layer    (lu_layer),
    .lu_code     (lu_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_offset  (out_offset),
    .out_mask    (out_mask),
    .out_hit     (out_hit)
`ifdef JTCPS1_BANKMAP_MISS_EN
    ,
    .miss_cnt    (miss_cnt),
    .miss_flag   (miss_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    logic [2:0] layer;
    logic [9:0] code;
    logic       hit;
    logic [3:0] off;
    logic [3:0] mask;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_rx     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int ph, input logic [2:0] l, input logic [9:0] c,
                     input logic h, input logic [3:0] o, input logic [3:0] m);
    vec_t v;
    v.ph = ph; v.layer = l; v.code = c; v.hit = h; v.off = o; v.mask = m;
    vecs.push_back(v);
  endtask

  // Result monitor: compare consumed results in order, check hold under stall.
  initial begin
    logic       held_v;
    logic [8:0] held;
    logic [8:0] cur;
    logic [8:0] exp;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      cur = {out_hit, out_offset, out_mask};
      if (!rst_n || !out_valid) begin
        held_v = 1'b0;
      end else begin
        if (held_v) chk("hold_stable", 32'(cur), 32'(held));
        if (out_ready) begin
          n_rx++;
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %0h expected none", cur);
          end else begin
            exp = sb.pop_front();
            chk("result", 32'(cur), 32'(exp));
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = cur;
        end
      end
    end
  end

  task automatic pw(input int e, input int b, input logic [7:0] d);
    prog_addr = 6'(e * 8 + b);
    prog_data = d;
    prog_we   = 1'b1;
    @(posedge clk);
    #1;
    prog_we   = 1'b0;
  endtask

  task automatic prog_entry(input int e, input logic [7:0] b0, input logic [15:0] lo,
                            input logic [15:0] hi, input logic [3:0] bank);
    pw(e, 0, b0);
    pw(e, 1, lo[7:0]);
    pw(e, 2, lo[15:8]);
    pw(e, 3, hi[7:0]);
    pw(e, 4, hi[15:8]);
    pw(e, 5, {4'h0, bank});
  endtask

  // Present one lookup, wait (bounded) for acceptance; result expected in order.
  task automatic issue(input logic [2:0] l, input logic [9:0] c, input logic h,
                       input logic [3:0] o, input logic [3:0] m);
    int n;
    lu_layer = l;
    lu_code  = c;
    lu_req   = 1'b1;
    sb.push_back({h, o, m});
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (lu_ready) break;
    end
    if (n == 64) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got lu_ready=0 expected 1 within 64 cycles");
    end
    @(posedge clk);
    #1;
    lu_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (n == 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].ph == ph)
        issue(vecs[i].layer, vecs[i].code, vecs[i].hit, vecs[i].off, vecs[i].mask);
    end
    drain();
  endtask

  initial begin
    int rx0;
    int cnt;
    logic saw_stall;

    // Banks: 0 {1,E}, 1 {5,3}, 2 {8,7}, 3 {C,1}
    bank_offset = {4'hC, 4'h8, 4'h5, 4'h1};
    bank_mask   = {4'h1, 4'h7, 4'h3, 4'hE};
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    lu_req = 1'b0; lu_layer = '0; lu_code = '0; out_ready = 1'b1;

    // Phase 2: entry0 layer1, 0x000-0x1FF, bank 2
    add(2, 3'd1, 10'h1FF, 1'b1, 4'h8, 4'h7);
    add(2, 3'd1, 10'h200, 1'b0, 4'h0, 4'hF);
    add(2, 3'd1, 10'h000, 1'b1, 4'h8, 4'h7);
    add(2, 3'd2, 10'h100, 1'b0, 4'h0, 4'hF);
    // Phase 3: overlapping ranges, out-of-range bank, single-code range
    add(3, 3'd2, 10'h150, 1'b1, 4'h5, 4'h3);
    add(3, 3'd2, 10'h050, 1'b1, 4'hC, 4'h1);
    add(3, 3'd2, 10'h2FF, 1'b1, 4'h5, 4'h3);
    add(3, 3'd2, 10'h300, 1'b1, 4'hC, 4'h1);
    add(3, 3'd1, 10'h150, 1'b0, 4'h0, 4'hF);
    add(3, 3'd4, 10'h010, 1'b1, 4'h0, 4'hF);
    add(3, 3'd0, 10'h020, 1'b1, 4'h1, 4'hE);
    add(3, 3'd0, 10'h021, 1'b0, 4'h0, 4'hF);
    add(3, 3'd3, 10'h006, 1'b1, 4'h8, 4'h7);
    add(3, 3'd3, 10'h008, 1'b0, 4'h0, 4'hF);
    // Phase 5: inverted range, layer codes beyond LAYERS
    add(5, 3'd1, 10'h100, 1'b0, 4'h0, 4'hF);
    add(5, 3'd1, 10'h200, 1'b0, 4'h0, 4'hF);
    add(5, 3'd1, 10'h300, 1'b0, 4'h0, 4'hF);
    add(5, 3'd6, 10'h010, 1'b0, 4'h0, 4'hF);
    add(5, 3'd5, 10'h010, 1'b0, 4'h0, 4'hF);
    add(5, 3'd7, 10'h010, 1'b0, 4'h0, 4'hF);
    add(5, 3'd4, 10'h010, 1'b1, 4'h1, 4'hE);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_offset", 32'(out_offset), 32'h0);
    chk("rst_out_mask", 32'(out_mask), 32'hF);
    chk("rst_out_hit", 32'(out_hit), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Unprogrammed lookup, two-cycle latency
    lu_layer = 3'd1; lu_code = 10'h123; lu_req = 1'b1;
    sb.push_back({1'b0, 4'h0, 4'hF});
    @(negedge clk);
    chk("first_lu_ready", 32'(lu_ready), 32'd1);
    @(posedge clk);
    #1;
    lu_req = 1'b0;
    @(negedge clk);
    chk("latency_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_c2_valid", 32'(out_valid), 32'd1);
    drain();

    prog_entry(0, 8'h82, 16'h0000, 16'h01FF, 4'd2);
    run_phase(2);

    prog_entry(0, 8'h84, 16'h0100, 16'h02FF, 4'd1);
    prog_entry(3, 8'h84, 16'h0000, 16'h03FF, 4'd3);
    prog_entry(5, 8'h90, 16'h0000, 16'h03FF, 4'd9);
    prog_entry(1, 8'h81, 16'h0020, 16'h0020, 4'd0);
    prog_entry(2, 8'h88, 16'hFC05, 16'hFC07, 4'd2);
    run_phase(3);

    // Back-to-back lookups with the consumer stalled for four cycles
    saw_stall = 1'b0;
    rx0 = n_rx;
    fork
      begin
        cnt = 0;
        foreach (vecs[i]) begin
          if (vecs[i].ph == 3 && cnt < 8) begin
            issue(vecs[i].layer, vecs[i].code, vecs[i].hit, vecs[i].off, vecs[i].mask);
            cnt++;
          end
        end
      end
      begin
        for (int c = 0; c < 14; c++) begin
          @(posedge clk);
          #1;
          out_ready = !(c >= 2 && c <= 5);
          @(negedge clk);
          if (lu_req && !lu_ready) saw_stall = 1'b1;
        end
      end
    join
    drain();
    chk("stall_lu_ready_dropped", 32'(saw_stall), 32'd1);
    chk("stall_all_delivered", 32'(n_rx - rx0), 32'd8);

    for (int e = 1; e < 8; e++) pw(e, 0, 8'h00);
    prog_entry(0, 8'h82, 16'h0300, 16'h0100, 4'd1);
    prog_entry(4, 8'hF0, 16'h0000, 16'h03FF, 4'd0);
    run_phase(5);

`ifdef JTCPS1_BANKMAP_MISS_EN
    pw(7, 6, 8'h00);
    chk("miss_cnt_cleared", 32'(miss_cnt), 32'd0);
    chk("miss_flag_cleared", 32'(miss_flag), 32'd0);
    for (int i = 0; i < 3; i++) issue(3'd1, 10'h200, 1'b0, 4'h0, 4'hF);
    drain();
    chk("miss_cnt_3", 32'(miss_cnt), 32'd3);
    chk("miss_flag_set", 32'(miss_flag), 32'd1);
    pw(7, 7, 8'h00);
    chk("miss_cnt_prog_clear", 32'(miss_cnt), 32'd0);
    chk("miss_flag_prog_clear", 32'(miss_flag), 32'd0);
`endif

    // Reset with a lookup in flight: it is discarded and the table is cleared
    issue(3'd4, 10'h010, 1'b1, 4'h1, 4'hE);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_mask", 32'(out_mask), 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx0 = n_rx;
    repeat (4) @(negedge clk);
    chk("midrst_no_ghost", 32'(n_rx - rx0), 32'd0);
    @(posedge clk);
    #1;
    issue(3'd4, 10'h010, 1'b0, 4'h0, 4'hF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
